// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits LATENCY
// cycles, executes against a word array, then holds the response until taken.
module dmem_responder #(
    parameter int MEM_SIZE = 1024,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic               wr_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic [31:0]        mem_r [MEM_SIZE];

    logic               accept_s;
    logic               exec_s;
    logic               op_write_s;
    logic               op_err_s;
    logic [31:0]        op_addr_s;
    logic [31:0]        op_wdata_s;
    logic [IDX_W-1:0]   op_idx_s;
    logic [31:0]        load_data_s;

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = (state_r == RESP);

    // Operand select and execution decode; with zero latency the live request executes directly.
    always_comb begin
        accept_s   = 1'b0;
        exec_s     = 1'b0;
        op_write_s = wr_r;
        op_addr_s  = addr_r;
        op_wdata_s = wdata_r;
        case (state_r)
            IDLE: begin
                accept_s   = req_valid;
                exec_s     = req_valid && (LATENCY == 0);
                op_write_s = req_write;
                op_addr_s  = req_addr;
                op_wdata_s = req_wdata;
            end
            WAIT:    exec_s = (cnt_r == 4'd0);
            default: exec_s = 1'b0;
        endcase
        op_err_s = (op_addr_s[1:0] != 2'b00) ||
                   ({2'b00, op_addr_s[31:2]} >= 32'(MEM_SIZE));
        op_idx_s = op_addr_s[IDX_W+1:2];
        if (op_err_s || op_write_s) begin
            load_data_s = 32'd0;
        end else begin
            load_data_s = mem_r[op_idx_s];
        end
    end

    // Transaction FSM, request capture and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            wr_r       <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (exec_s) begin
                resp_rdata <= load_data_s;
                resp_err   <= op_err_s;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        wr_r    <= req_write;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        if (LATENCY == 0) begin
                            state_r <= RESP;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Word array: no reset, so contents survive reset; writes gated off while reset is held.
    always_ff @(posedge clk) begin
        if (exec_s && reset && op_write_s && !op_err_s) begin
            mem_r[op_idx_s] <= op_wdata_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 at LATENCY=2, instance 1 at LATENCY=0,
// random and directed traffic checked against an array-based memory model.
module tb_dmem_responder;

    localparam int MS = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          known;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc [2];
    int lat_of   [2];
    bit rr_rand = 1'b0;
    bit rr_val  = 1'b1;

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] mdata  [2][MS];
    bit          mknown [2][MS];

    dmem_responder #(.MEM_SIZE(MS), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.MEM_SIZE(MS), .LATENCY(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic int qsz(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i, output exp_t e);
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    // Reference behaviour: word-addressed array, bounds/alignment rule, stores read back 0.
    function automatic exp_t model(input int i, input logic w, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t e;
        int   idx;
        idx     = int'(a >> 2);
        e.err   = (a % 4 != 0) || (a / 4 >= MS);
        e.rdata = 32'd0;
        e.known = 1'b1;
        e.acc   = cyc;
        if (!e.err) begin
            if (w) begin
                mdata[i][idx]  = d;
                mknown[i][idx] = 1'b1;
            end else begin
                e.rdata = mdata[i][idx];
                e.known = mknown[i][idx];
            end
        end
        return e;
    endfunction

    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit record);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            fail_now("req_ready_wait");
            return;
        end
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        if (record) begin
            e = model(i, w, a, d);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        last_acc[i] = cyc;
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
    endtask

    task automatic drain(input int i);
        int n = 0;
        while ((qsz(i) != 0 || !req_ready[i]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (qsz(i) != 0 || !req_ready[i]) fail_now("drain");
    endtask

    task automatic wait_resp(input int i);
        int n = 0;
        while (!resp_valid[i] && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid[i]) fail_now("resp_wait");
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return 32'($urandom_range(0, 15)) * 32'd4 + 32'h0000_0100;
        if (r == 7) return 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
        if (r == 8) return (r[0] ? 32'h0000_0FFC : 32'h0000_1000);
        return $urandom;
    endfunction

    task automatic mon(input int i);
        bit          pv = 1'b0;
        bit          pr = 1'b0;
        logic [31:0] pd = 32'd0;
        logic        pe = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                pv = 1'b0;
                continue;
            end
            if (resp_valid[i]) begin
                if (!pv) begin
                    if (qsz(i) == 0) fail_now("unexpected_resp");
                    else chk("resp_latency", 32'(cyc), 32'(qhead(i).acc + lat_of[i] + 1));
                end else if (!pr) begin
                    chk("hold_rdata", resp_rdata[i], pd);
                    chk("hold_err", 32'(resp_err[i]), 32'(pe));
                end
                if (resp_ready[i]) begin
                    if (qsz(i) == 0) begin
                        fail_now("empty_scoreboard");
                    end else begin
                        qpop(i, e);
                        chk("resp_err", 32'(resp_err[i]), 32'(e.err));
                        if (e.known) chk("resp_rdata", resp_rdata[i], e.rdata);
                    end
                end
            end
            pv = resp_valid[i];
            pr = resp_ready[i];
            pd = resp_rdata[i];
            pe = resp_err[i];
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        resp_ready[0] = 1'b1;
        resp_ready[1] = 1'b1;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                resp_ready[k] = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          prev;
        logic [31:0] v;
        lat_of[0] = 2;
        lat_of[1] = 0;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
            last_acc[k]  = 0;
            for (int j = 0; j < MS; j++) mknown[k][j] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
            chk("rst_resp_rdata", resp_rdata[k], 32'd0);
            chk("rst_resp_err", 32'(resp_err[k]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready0", 32'(req_ready[0]), 32'd1);
        chk("rst_req_ready1", 32'(req_ready[1]), 32'd1);

        // Directed store/load, misaligned, out-of-range and last-word cases.
        issue(0, 1'b1, 32'h0000_015C, 32'd21, 1'b1);
        issue(0, 1'b0, 32'h0000_015C, 32'd0, 1'b1);
        issue(0, 1'b1, 32'h0000_015D, 32'd99, 1'b1);
        issue(0, 1'b0, 32'h0000_015C, 32'd0, 1'b1);
        issue(0, 1'b0, 32'h0000_1000, 32'd0, 1'b1);
        issue(0, 1'b1, 32'h0000_0FFC, 32'hA5A5_5A5A, 1'b1);
        issue(0, 1'b0, 32'h0000_0FFC, 32'd0, 1'b1);
        drain(0);

        // Backpressure: response held, extra requests ignored.
        rr_val = 1'b0;
        issue(0, 1'b0, 32'h0000_015C, 32'd0, 1'b1);
        wait_resp(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
            chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
            req_valid[0] = 1'(k % 2 == 0);
            req_write[0] = 1'b1;
            req_addr[0]  = 32'h0000_015C;
            req_wdata[0] = $urandom;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        rr_val = 1'b1;
        drain(0);
        issue(0, 1'b0, 32'h0000_015C, 32'd0, 1'b1);
        drain(0);

        // Reset in RESP: executed store persists, response dropped.
        rr_val = 1'b0;
        v = $urandom;
        issue(0, 1'b1, 32'h0000_0040, v, 1'b1);
        wait_resp(0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_resp_drop", 32'(resp_valid[0]), 32'd0);
        if (q0.size() > 0) void'(q0.pop_front());
        @(negedge clk);
        reset  = 1'b1;
        rr_val = 1'b1;
        issue(0, 1'b0, 32'h0000_0040, 32'd0, 1'b1);

        // Reset in WAIT: pending store must not reach memory.
        issue(0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b1);
        issue(0, 1'b0, 32'h0000_0020, 32'd0, 1'b1);
        drain(0);
        issue(0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("rstw_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rstw_resp_rdata", resp_rdata[0], 32'd0);
        chk("rstw_resp_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_req_ready", 32'(req_ready[0]), 32'd1);
        issue(0, 1'b0, 32'h0000_0020, 32'd0, 1'b1);
        drain(0);

        // Random traffic with random response backpressure.
        rr_rand = 1'b1;
        for (int k = 0; k < 150; k++) begin
            issue(0, 1'($urandom), rand_addr(), $urandom, 1'b1);
        end
        rr_rand = 1'b0;
        rr_val  = 1'b1;
        drain(0);

        // Zero-latency instance: back-to-back every two cycles.
        v = $urandom;
        issue(1, 1'b1, 32'h0000_0008, v, 1'b1);
        for (int k = 0; k < 4; k++) begin
            prev = last_acc[1];
            issue(1, 1'b0, (k == 3) ? 32'h0000_0003 : 32'h0000_0008, 32'd0, 1'b1);
            chk("b2b_spacing", 32'(last_acc[1] - prev), 32'd2);
        end
        drain(1);
        rr_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            issue(1, 1'($urandom), rand_addr(), $urandom, 1'b1);
        end
        rr_rand = 1'b0;
        rr_val  = 1'b1;
        drain(1);
        drain(0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 0..15.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request this cycle.
REQ-007 SHALL have port req_write, input, 1, 1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr, input, 32, byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata, input, 32, store data.
REQ-010 SHALL have port resp_valid, output, 1, response available.
REQ-011 SHALL have port resp_ready, input, 1, initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32, load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1, request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; exactly one transaction outstanding.
REQ-015 req_ready SHALL equal 1 exactly when state is IDLE (combinational from state only, not from req_valid).
REQ-016 Request accepted on rising edge where req_valid && req_ready; req_write, req_addr, req_wdata SHALL be captured into internal registers at that edge.
REQ-017 On acceptance: LATENCY > 0 -> WAIT with wait counter loaded to LATENCY-1; LATENCY == 0 -> RESP directly.
REQ-018 In WAIT the counter SHALL decrement each cycle; when counter == 0 the FSM SHALL enter RESP on the next edge, giving exactly LATENCY cycles in WAIT.
REQ-019 Execution edge (entry into RESP) SHALL perform the memory access and load resp_rdata/resp_err.
REQ-020 Error condition: captured addr[1:0] != 0 or addr[31:2] >= MEM_SIZE; on error: no memory write, resp_rdata = 0, resp_err = 1.
REQ-021 Valid store: mem[addr[31:2]] <= wdata at execution edge; resp_rdata = 0, resp_err = 0.
REQ-022 Valid load: resp_rdata = mem[addr[31:2]] as of the execution edge, resp_err = 0.
REQ-023 resp_valid SHALL equal 1 exactly when state is RESP; resp_rdata/resp_err SHALL be held stable while resp_valid && !resp_ready.
REQ-024 RESP -> IDLE on edge where resp_ready == 1; if resp_ready is already 1 on the RESP entry edge... response still lasts at least one cycle (resp_ready sampled only while in RESP).
REQ-025 req_valid while not IDLE SHALL be ignored (no capture, no state effect); initiator holds it until req_ready.
REQ-026 Minimum spacing: one transaction per LATENCY+2 cycles (accept, LATENCY wait, one RESP cycle).
REQ-027 Memory contents SHALL be uninitialised (X) until written; no initial load.
REQ-028 Load from a word stored by the immediately previous transaction SHALL return the new value.

Reset
REQ-029 reset == 0 SHALL immediately force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1 after deassertion.
REQ-030 Reset during WAIT SHALL drop the transaction; a store not yet executed SHALL NOT modify memory.
REQ-031 Reset during RESP SHALL drop the pending response; an already-executed store remains in memory.
REQ-032 Reset SHALL NOT clear memory contents.

Verification
REQ-033 LATENCY=2: store addr 0x15C data 21, resp_ready=1 -> resp_valid exactly 3 cycles after acceptance edge, resp_err 0; then load 0x15C -> resp_rdata 21.
REQ-034 Misaligned store addr 0x15D data 99 -> resp_err 1, resp_rdata 0; subsequent load 0x15C still returns 21.
REQ-035 Out-of-range load addr 0x1000 (MEM_SIZE 1024) -> resp_err 1, resp_rdata 0.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata stable; req_ready 0 throughout; req_valid pulses ignored.
REQ-037 Reset low in WAIT of store addr 0x20 data 0xDEADBEEF -> outputs zeroed immediately; later load 0x20 does not return 0xDEADBEEF.
REQ-038 LATENCY=0: load accepted -> resp_valid next cycle; back-to-back transactions with resp_ready=1 complete every 2 cycles.
